gcd_result_capture: RTL and testbench

- Downstream consumer of the GCD processor: watches `halt` and `out`, latches each finished result on the rising edge of `halt`.
- Converts the 8-bit result to three BCD digits with an iterative shift-add-3 (double dabble) engine, one bit per cycle, for the board display.
- Keeps a small circular history of raw results plus a saturating result counter for bench and debug readback.

---
 rtl/gcd_result_capture.sv | 117 +++++++++++
 tb/tb_gcd_result_capture.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gcd_result_capture.sv
// Captures each GCD result on the rising edge of halt, converts it to three BCD digits
// with a one-bit-per-cycle double-dabble engine, and keeps a small history plus a result counter.
module gcd_result_capture #(
  parameter int DEPTH = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic [7:0]       out,
  input  logic [SEL_W-1:0] hist_sel,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             bcd_valid,
  output logic             busy,
  output logic             dropped,
  output logic [7:0]       result_count,
  output logic [7:0]       hist_data
);

  typedef enum logic {IDLE, CONV} state_e;

  state_e           state;
  state_e           stateNext;
  logic             haltD;
  logic             cap;
  logic             startConv;
  logic             lastBit;
  logic [19:0]      shiftReg;
  logic [19:0]      adjusted;
  logic [19:0]      shiftNext;
  logic [2:0]       bitCnt;
  logic [SEL_W-1:0] wp;
  logic [SEL_W-1:0] rdIdx;
  logic [7:0]       hist [DEPTH];

  // haltD resets high so a halt already asserted at reset release is ignored
  assign cap = halt & ~haltD;

  always_comb begin
    stateNext = state;
    startConv = 1'b0;
    lastBit   = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          stateNext = CONV;
          startConv = 1'b1;
        end
      end
      CONV: begin
        if (bitCnt == 3'd7) begin
          stateNext = IDLE;
          lastBit   = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    adjusted = shiftReg;
    if (adjusted[19:16] >= 4'd5) adjusted[19:16] = adjusted[19:16] + 4'd3;
    if (adjusted[15:12] >= 4'd5) adjusted[15:12] = adjusted[15:12] + 4'd3;
    if (adjusted[11:8]  >= 4'd5) adjusted[11:8]  = adjusted[11:8]  + 4'd3;
    shiftNext = {adjusted[18:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      haltD        <= 1'b1;
      shiftReg     <= '0;
      bitCnt       <= '0;
      wp           <= '0;
      bcd_hund     <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      bcd_valid    <= 1'b0;
      busy         <= 1'b0;
      dropped      <= 1'b0;
      result_count <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      haltD <= halt;
      if (startConv) begin
        shiftReg  <= {12'b0, out};
        bitCnt    <= '0;
        hist[wp]  <= out;
        wp        <= wp + SEL_W'(1);
        bcd_valid <= 1'b0;
        busy      <= 1'b1;
        if (result_count != 8'hFF) result_count <= result_count + 8'd1;
      end else if (state == CONV) begin
        shiftReg <= shiftNext;
        bitCnt   <= bitCnt + 3'd1;
        if (cap) dropped <= 1'b1;
        if (lastBit) begin
          bcd_hund  <= shiftNext[19:16];
          bcd_tens  <= shiftNext[15:12];
          bcd_ones  <= shiftNext[11:8];
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end

  assign rdIdx     = wp - SEL_W'(1) - hist_sel;
  assign hist_data = hist[rdIdx];

endmodule

// File: tb/tb_gcd_result_capture.sv
// Directed bench for gcd_result_capture: conversion latency, drops, history wrap, reset and saturation.
module tb_gcd_result_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       halt;
  logic [7:0] out;
  logic [1:0] histSel;
  logic [3:0] bcdHund, bcdTens, bcdOnes;
  logic       bcdValid, busy, dropped;
  logic [7:0] resultCount, histData;

  int checks = 0;
  int errors = 0;

  gcd_result_capture #(.DEPTH(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .halt(halt), .out(out), .hist_sel(histSel),
    .bcd_hund(bcdHund), .bcd_tens(bcdTens), .bcd_ones(bcdOnes),
    .bcd_valid(bcdValid), .busy(busy), .dropped(dropped),
    .result_count(resultCount), .hist_data(histData)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; halt = 1'b0; out = 8'd0; histSel = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic histAt(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    histSel = sel;
    #1;
    chk(tag, histData, exp);
    histSel = 2'd0;
    #1;
  endtask

  // One full capture: busy across E0..E7, digits at E8, then halt drops.
  task automatic runOne(input logic [7:0] v, input logic [3:0] h, input logic [3:0] t,
                        input logic [3:0] o, input string tag);
    out = v; halt = 1'b1;
    tick();
    chk({tag, ".busyStart"}, busy, 1);
    chk({tag, ".validClr"}, bcdValid, 0);
    repeat (7) tick();
    chk({tag, ".busyE7"}, busy, 1);
    tick();
    chk({tag, ".busyDone"}, busy, 0);
    chk({tag, ".valid"}, bcdValid, 1);
    chk({tag, ".digits"}, {bcdHund, bcdTens, bcdOnes}, {h, t, o});
    halt = 1'b0;
    tick();
  endtask

  initial begin
    doReset();
    chk("rst.digits", {bcdHund, bcdTens, bcdOnes}, 0);
    chk("rst.flags", {bcdValid, busy, dropped}, 0);
    chk("rst.count", resultCount, 0);
    chk("rst.hist", histData, 0);

    // Test 1
    runOne(8'd37, 4'd0, 4'd3, 4'd7, "t1");
    chk("t1.count", resultCount, 1);
    histAt(2'd0, 8'd37, "t1.hist0");
    histAt(2'd1, 8'd0, "t1.hist1Empty");

    // Test 2
    runOne(8'd255, 4'd2, 4'd5, 4'd5, "t2a");
    runOne(8'd0, 4'd0, 4'd0, 4'd0, "t2b");
    chk("t2.count", resultCount, 3);
    tick();
    chk("t2.holdValid", bcdValid, 1);

    // Test 3: second rise lands mid-conversion and is dropped
    doReset();
    out = 8'd12; halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    tick();
    out = 8'd99; halt = 1'b1;
    tick();
    chk("t3.dropped", dropped, 1);
    halt = 1'b0;
    repeat (5) tick();
    chk("t3.digits", {bcdHund, bcdTens, bcdOnes}, {4'd0, 4'd1, 4'd2});
    chk("t3.valid", bcdValid, 1);
    chk("t3.count", resultCount, 1);
    histAt(2'd0, 8'd12, "t3.hist0");
    histAt(2'd1, 8'd0, "t3.hist1");
    runOne(8'd99, 4'd0, 4'd9, 4'd9, "t3b");
    chk("t3b.count", resultCount, 2);
    chk("t3b.droppedSticky", dropped, 1);

    // Test 4: history wrap
    doReset();
    runOne(8'd4, 4'd0, 4'd0, 4'd4, "t4a");
    runOne(8'd8, 4'd0, 4'd0, 4'd8, "t4b");
    runOne(8'd15, 4'd0, 4'd1, 4'd5, "t4c");
    runOne(8'd16, 4'd0, 4'd1, 4'd6, "t4d");
    runOne(8'd23, 4'd0, 4'd2, 4'd3, "t4e");
    histAt(2'd0, 8'd23, "t4.h0");
    histAt(2'd1, 8'd16, "t4.h1");
    histAt(2'd2, 8'd15, "t4.h2");
    histAt(2'd3, 8'd8, "t4.h3");
    chk("t4.count", resultCount, 5);
    chk("t4.noDrop", dropped, 0);

    // Test 5: reset mid-conversion with halt held high
    doReset();
    out = 8'd200; halt = 1'b1;
    tick();
    repeat (3) tick();
    chk("t5.busyBefore", busy, 1);
    reset = 1'b1;
    tick();
    chk("t5.digits", {bcdHund, bcdTens, bcdOnes}, 0);
    chk("t5.flags", {bcdValid, busy, dropped}, 0);
    chk("t5.count", resultCount, 0);
    chk("t5.hist", histData, 0);
    reset = 1'b0;
    repeat (12) tick();
    chk("t5.noCapBusy", busy, 0);
    chk("t5.noCapCount", resultCount, 0);
    chk("t5.noCapValid", bcdValid, 0);
    halt = 1'b0;
    tick();
    runOne(8'd200, 4'd2, 4'd0, 4'd0, "t5b");
    chk("t5b.count", resultCount, 1);

    // Test 6: counter saturation
    doReset();
    for (int i = 0; i < 256; i++) begin
      out = i[7:0]; halt = 1'b1;
      tick();
      halt = 1'b0;
      repeat (9) tick();
    end
    chk("t6.sat", resultCount, 255);
    histAt(2'd0, 8'd255, "t6.hist0");
    runOne(8'd42, 4'd0, 4'd4, 4'd2, "t6b");
    chk("t6b.satHold", resultCount, 255);
    histAt(2'd0, 8'd42, "t6b.hist0");
    histAt(2'd1, 8'd255, "t6b.hist1");
    chk("t6b.noDrop", dropped, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
